// File: rtl/ntt_bram_scheduler_pkg.sv
// Shared types and constants for the NTT coefficient-BRAM scheduler.
package ntt_sched_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OWNER_HOST = 1'b0;
  localparam logic OWNER_ENG  = 1'b1;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 12;

  // One entry per BRAM pipeline stage; travels with the strobe so dout can be steered.
  typedef struct packed {
    logic host_req;
    logic eng_req;
    logic owner;
    logic grant;
  } tag_t;
endpackage

// File: rtl/ntt_bram_scheduler_if.sv
// Single-port BRAM style bus: requester drives en/we/addr/din, responder returns dout.
interface ntt_bram_scheduler_if
  import ntt_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output en, we, addr, din, input dout);
  modport slave  (input en, we, addr, din, output dout);
endinterface

// File: rtl/ntt_bram_scheduler_port_mux.sv
// Registered owner mux onto the BRAM plus the 2-stage tag pipeline that routes
// read data back to whichever requester issued the strobe.
module ntt_bram_port_mux
  import ntt_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 grant_i,
  input  logic                 owner_i,
  ntt_bram_scheduler_if.slave  host,
  ntt_bram_scheduler_if.slave  eng,
  ntt_bram_scheduler_if.master bram
);
  logic              bram_en_d, bram_en_q, bram_we_d, bram_we_q;
  logic [ADDR_W-1:0] bram_addr_d, bram_addr_q;
  logic [DATA_W-1:0] bram_din_d, bram_din_q;
  logic [DATA_W-1:0] host_dout_d, host_dout_q, eng_dout_d, eng_dout_q;
  tag_t              tag_in;
  tag_t [1:0]        tag_d, tag_q;
  logic              sel_eng;

  always_comb begin
    sel_eng     = (owner_i == OWNER_ENG);
    bram_en_d   = grant_i & (sel_eng ? eng.en : host.en);
    bram_we_d   = bram_en_d & (sel_eng ? eng.we : host.we);
    bram_addr_d = sel_eng ? eng.addr : host.addr;
    bram_din_d  = sel_eng ? eng.din  : host.din;
    tag_in      = '{host_req: host.en, eng_req: eng.en, owner: owner_i, grant: grant_i};
    tag_d       = {tag_q[0], tag_in};
    // A requester that was not served gets zero back; the other one keeps its last word.
    host_dout_d = host_dout_q;
    eng_dout_d  = eng_dout_q;
    if (tag_q[1].host_req)
      host_dout_d = (tag_q[1].grant && tag_q[1].owner == OWNER_HOST) ? bram.dout : '0;
    if (tag_q[1].eng_req)
      eng_dout_d  = (tag_q[1].grant && tag_q[1].owner == OWNER_ENG)  ? bram.dout : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      tag_q       <= '0;
      host_dout_q <= '0;
      eng_dout_q  <= '0;
    end else begin
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      tag_q       <= tag_d;
      host_dout_q <= host_dout_d;
      eng_dout_q  <= eng_dout_d;
    end
  end

  assign bram.en   = bram_en_q;
  assign bram.we   = bram_we_q;
  assign bram.addr = bram_addr_q;
  assign bram.din  = bram_din_q;
  assign host.dout = host_dout_d;
  assign eng.dout  = eng_dout_d;
endmodule

// File: rtl/ntt_bram_scheduler.sv
// Transform sequencer for the NTT unit: hands the coefficient BRAM from host to engine
// and back, with watchdog abort and sticky irq/err flags.
module ntt_bram_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic                 irq_ack_i,
  input  logic                 eng_done_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 irq_o,
  output logic                 eng_go_o,
  output logic                 eng_mode_o,
  ntt_bram_scheduler_if.slave  host,
  ntt_bram_scheduler_if.slave  eng,
  ntt_bram_scheduler_if.master bram
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e            state_d, state_q;
  logic              start_prev_q, mode_d, mode_q, go_d, go_q, busy_d, busy_q;
  logic              err_d, err_q, irq_d, irq_q;
  logic [WD_W-1:0]   wd_d, wd_q;
  logic              start_edge, abort, done_set, clr_err;
  logic              grant, owner;

  always_comb begin
    start_edge = start_i & ~start_prev_q;
    state_d    = state_q;
    mode_d     = mode_q;
    wd_d       = wd_q;
    go_d       = 1'b0;
    abort      = 1'b0;
    done_set   = 1'b0;
    clr_err    = 1'b0;
    case (state_q)
      IDLE: if (start_edge) begin
        state_d = ARM;
        mode_d  = mode_i;
        wd_d    = '0;
        clr_err = 1'b1;
      end
      ARM: begin
        state_d = RUN;
        go_d    = 1'b1;
      end
      RUN: begin
        wd_d = wd_q + 1'b1;
        // Done on the last allowed cycle still counts as a normal completion.
        if (eng_done_i)                            state_d = DONE;
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin state_d = IDLE; abort = 1'b1; end
      end
      DONE: begin
        state_d  = IDLE;
        done_set = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_q;
    irq_d = irq_q;
    if (irq_ack_i) begin
      err_d = 1'b0;
      irq_d = 1'b0;
    end
    if (clr_err) err_d = 1'b0;
    if (abort || (host.en && state_q != IDLE)) err_d = 1'b1;
    if (abort || done_set)                     irq_d = 1'b1;
    busy_d = (state_d != IDLE);
    grant  = (state_q == IDLE) || (state_q == RUN);
    owner  = (state_q == RUN) ? OWNER_ENG : OWNER_HOST;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      mode_q       <= 1'b0;
      go_q         <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_i;
      mode_q       <= mode_d;
      go_q         <= go_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      irq_q        <= irq_d;
      wd_q         <= wd_d;
    end
  end

  assign busy_o     = busy_q;
  assign err_o      = err_q;
  assign irq_o      = irq_q;
  assign eng_go_o   = go_q;
  assign eng_mode_o = mode_q;

  ntt_bram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .grant_i (grant),
    .owner_i (owner),
    .host    (host),
    .eng     (eng),
    .bram    (bram)
  );
endmodule
